// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and step modes for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration: radix-2 shift-add multiply or restoring shift-subtract divide.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  mode_t              i_mode,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    // Multiply: acc = {partial product high, remaining multiplier}; the carry shifts into the top.
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
    w_ge     = (w_rem_sh >= {1'b0, i_opnd});
    w_diff   = w_rem_sh[WIDTH-1:0] - i_opnd;
    if (i_mode == MODE_DIV) begin
      o_acc = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), i_acc[WIDTH-2:0], w_ge};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO unit: MULT/MULTU/DIV/DIVU over WIDTH steps plus a sign-fix cycle, and MTHI/MTLO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  mode_t              r_mode;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_b_zero;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_is_div;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_acc_fix;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_signed  = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_a_mag   = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_b_mag   = (w_signed && B[WIDTH-1]) ? -B : B;

  // Negating the whole accumulator also yields the negated quotient in its low half.
  assign w_acc_fix = r_neg_q ? -r_acc : r_acc;
  assign w_rem     = r_acc[2*WIDTH-1:WIDTH];
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_mode (r_mode),
    .o_acc  (w_acc_nxt)
  );

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_mode   <= MODE_MUL;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_busy   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                r_mode   <= w_is_div ? MODE_DIV : MODE_MUL;
                r_neg_q  <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                r_neg_r  <= w_signed && A[WIDTH-1];
                r_b_zero <= (B == '0);
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_state  <= ST_RUN;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          // Divide by zero leaves |A| as remainder, so the dividend-sign fix restores A exactly.
          if (r_mode == MODE_DIV) begin
            r_lo <= r_b_zero ? '1 : w_acc_fix[WIDTH-1:0];
            r_hi <= w_rem_fix;
          end else begin
            {r_hi, r_lo} <= w_acc_fix;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed HI/LO cases plus random mult/div against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          busy;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    logic signed [63:0] sa, sbv, q, r;
    logic [63:0] p;
    sa  = 64'($signed(a));
    sbv = 64'($signed(b));
    eh  = m_hi;
    el  = m_lo;
    case (o)
      OP_MULT:  begin p = sa * sbv; eh = p[63:32]; el = p[31:0]; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      OP_DIV: begin
        if (b == 0) begin el = 32'hFFFFFFFF; eh = a; end
        else begin q = sa / sbv; r = sa % sbv; el = q[31:0]; eh = r[31:0]; end
      end
      OP_DIVU: begin
        if (b == 0) begin el = 32'hFFFFFFFF; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
      OP_MTHI: eh = a;
      OP_MTLO: el = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string nm);
    exp_t e;
    model(o, a, b, e.hi, e.lo);
    m_hi = e.hi;
    m_lo = e.lo;
    if (o <= OP_DIVU) begin
      e.nm = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 200);
    if (busy) begin
      total++;
      bad++;
      $display("FAIL timeout: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string nm);
    int n;
    issue(o, a, b, nm);
    chk({nm, "_busy_start"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({nm, "_latency"}, 32'(n), 32'd33);
  endtask

  initial begin : monitor
    logic pb;
    exp_t e;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && pb && !busy) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: hi=%h lo=%h, required no completion", hi, lo);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_hi"}, hi, e.hi);
          chk({e.nm, "_lo"}, lo, e.lo);
        end
      end
      pb = busy;
    end
  end

  initial begin : stimulus
    logic [31:0] ra, rb;
    int n;
    rst = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst = 1'b1;

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, "multu_max");
    run_op(OP_MULT,  32'hFFFFFFFF, 32'd2, "mult_neg");
    run_op(OP_DIVU,  32'd100,      32'd7, "divu_100_7");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2, "div_neg7_2");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(OP_DIVU,  32'd5,        32'd0, "divu_by0");
    run_op(OP_DIV,   32'hFFFFFFFB, 32'd0, "div_neg_by0");

    issue(OP_MTLO, 32'h0000ABCD, 32'd0, "mtlo");
    chk("mtlo_lo", lo, m_lo);
    chk("mtlo_hi", hi, m_hi);
    chk("mtlo_busy", 32'(busy), 32'd0);
    issue(OP_MTHI, 32'h000055AA, 32'd0, "mthi");
    chk("mthi_hi", hi, m_hi);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(3'b110, 32'hDEADBEEF, 32'd3, "undef6");
    issue(3'b111, 32'hCAFEF00D, 32'd3, "undef7");
    chk("undef_hi", hi, m_hi);
    chk("undef_lo", lo, m_lo);
    chk("undef_busy", 32'(busy), 32'd0);

    // MTHI arriving mid-multiply must be dropped.
    issue(OP_MULT, 32'd7, 32'hFFFFFFFD, "mult_mthi_ignored");
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; A = 32'h00001234;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    repeat (2) @(negedge clk);
    chk("mthi_ignored_hi", hi, m_hi);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h80000000;
        1: ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      run_op(3'($urandom_range(0, 3)), ra, rb, "rand");
    end

    // Asynchronous reset partway through a divide.
    issue(OP_DIVU, 32'd1000, 32'd7, "divu_reset");
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op(OP_MULTU, 32'd3, 32'd4, "multu_after_rst");

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
